sram_port_arbiter: RTL and testbench

- Shares the core's single SRAM-like memory port between the fetch-stage instruction requester and the ex/io-stage data requester.
- Routes in-order responses back to the requester that issued them.
- Discards fetch responses cancelled by a WB exception or eret flush.
- Sits between the pipeline stages and the external bus bridge.

---
 rtl/sram_arbiter_params.sv | 23 ++
 rtl/pending_tag_fifo.sv | 72 +++++++
 rtl/sram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_params.sv
// Shared types for the SRAM port arbiter: response source tags, pending-FIFO
// entries and the arbiter state encoding.
package sram_arbiter_params;

    typedef enum logic {
        SOURCE_INST = 1'b0,
        SOURCE_DATA = 1'b1
    } source_tag_e;

    typedef struct packed {
        source_tag_e source;
        logic        cancelled;
    } pending_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/pending_tag_fifo.sv
// In-order tag FIFO for requests accepted by the bus but not yet answered.
// cancel_inst marks every stored fetch entry so its response is dropped.
module pending_tag_fifo
    import sram_arbiter_params::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  pending_entry_t push_entry,
    input  logic           pop,
    input  logic           cancel_inst,
    output pending_entry_t head,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pending_entry_t [DEPTH-1:0] entry_reg;
    pending_entry_t [DEPTH-1:0] entry_next;
    logic [PTR_W-1:0]           wr_ptr_reg;
    logic [PTR_W-1:0]           rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;
    logic                       push_eff;
    logic                       pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;
    assign head     = entry_reg[rd_ptr_reg];

    // A fresh push wins over the cancel broadcast; the caller pre-cancels it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                entry_next[gi] = entry_reg[gi];
                if (push_eff && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_next[gi] = push_entry;
                end else if (cancel_inst && (entry_reg[gi].source == SOURCE_INST)) begin
                    entry_next[gi].cancelled = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            entry_reg <= entry_next;
            if (push_eff) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_eff)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus port between fetch and data requesters, routing
// in-order responses back and dropping fetch responses killed by a flush.
module sram_port_arbiter
    import sram_arbiter_params::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [3:0]            data_wstrb,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_WIDTH-1:0] data_rdata,
    input  logic                  flush,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [3:0]            bus_wstrb,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy
);

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [3:0]            wstrb;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } held_request_t;

    arb_state_e     state_reg, state_next;
    held_request_t  held_reg, held_next;
    logic           hold_cancel_reg, hold_cancel_next;
    held_request_t  req_sel;
    held_request_t  data_fields;
    held_request_t  inst_fields;
    logic           bus_req_c;
    logic           inst_addr_ok_c;
    logic           data_addr_ok_c;
    logic           push;
    pending_entry_t push_entry;
    pending_entry_t head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           inst_resp_c;
    logic           data_resp_c;

    assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                           addr: data_addr, wdata: data_wdata};
    assign inst_fields = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'b0000,
                           addr: inst_addr, wdata: '0};

    always_comb begin
        state_next       = state_reg;
        held_next        = held_reg;
        hold_cancel_next = hold_cancel_reg;
        req_sel          = '0;
        bus_req_c        = 1'b0;
        inst_addr_ok_c   = 1'b0;
        data_addr_ok_c   = 1'b0;
        push             = 1'b0;
        push_entry       = '{source: SOURCE_INST, cancelled: 1'b0};
        case (state_reg)
            IDLE: begin
                if (!fifo_full && data_req) begin
                    bus_req_c = 1'b1;
                    req_sel   = data_fields;
                    if (bus_addr_ok) begin
                        data_addr_ok_c = 1'b1;
                        push           = 1'b1;
                        push_entry     = '{source: SOURCE_DATA, cancelled: 1'b0};
                    end else begin
                        held_next  = data_fields;
                        state_next = HOLD_DATA;
                    end
                end else if (!fifo_full && inst_req) begin
                    bus_req_c = 1'b1;
                    req_sel   = inst_fields;
                    if (bus_addr_ok) begin
                        inst_addr_ok_c = 1'b1;
                        push           = 1'b1;
                        push_entry     = '{source: SOURCE_INST, cancelled: flush};
                    end else begin
                        held_next        = inst_fields;
                        hold_cancel_next = flush;
                        state_next       = HOLD_INST;
                    end
                end
            end
            HOLD_INST: begin
                bus_req_c = 1'b1;
                req_sel   = held_reg;
                // A flushed fetch still has to finish its bus handshake.
                if (bus_addr_ok) begin
                    inst_addr_ok_c   = ~(hold_cancel_reg | flush);
                    push             = 1'b1;
                    push_entry       = '{source: SOURCE_INST,
                                         cancelled: hold_cancel_reg | flush};
                    hold_cancel_next = 1'b0;
                    state_next       = IDLE;
                end else if (flush) begin
                    hold_cancel_next = 1'b1;
                end
            end
            HOLD_DATA: begin
                bus_req_c = 1'b1;
                req_sel   = held_reg;
                if (bus_addr_ok) begin
                    data_addr_ok_c = 1'b1;
                    push           = 1'b1;
                    push_entry     = '{source: SOURCE_DATA, cancelled: 1'b0};
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            held_reg        <= '0;
            hold_cancel_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            held_reg        <= held_next;
            hold_cancel_reg <= hold_cancel_next;
        end
    end

    pending_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_pending (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (bus_data_ok),
        .cancel_inst(flush),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign data_resp_c = bus_data_ok & ~fifo_empty & (head.source == SOURCE_DATA);
    assign inst_resp_c = bus_data_ok & ~fifo_empty & (head.source == SOURCE_INST)
                       & ~head.cancelled & ~flush;

    // Every output is gated so an asserted reset silences the port instantly.
    assign bus_req      = ~reset & bus_req_c;
    assign bus_wr       = ~reset & req_sel.wr;
    assign bus_size     = reset ? 2'b00 : req_sel.size;
    assign bus_wstrb    = reset ? 4'b0000 : req_sel.wstrb;
    assign bus_addr     = reset ? '0 : req_sel.addr;
    assign bus_wdata    = reset ? '0 : req_sel.wdata;
    assign inst_addr_ok = ~reset & inst_addr_ok_c;
    assign data_addr_ok = ~reset & data_addr_ok_c;
    assign inst_data_ok = ~reset & inst_resp_c;
    assign data_data_ok = ~reset & data_resp_c;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;
    assign busy         = ~reset & ((state_reg != IDLE) | ~fifo_empty);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: stimulus pushes expected responses into a queue, a monitor
// pops and compares whenever either requester sees data_ok.
module tb_sram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [3:0]  data_wstrb = 4'h0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        flush = 1'b0;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .flush(flush),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    endtask

    task automatic expect_resp(input logic is_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        exp_q.push_back(e);
    endtask

    // Response monitor: samples mid-low-phase, after the stimulus has settled.
    always @(negedge clock) begin
        #2;
        if (inst_data_ok && data_data_ok) begin
            chk("resp_both_ok", 32'd1, 32'd0);
        end else if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {31'd0, data_data_ok}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_source", {31'd0, data_data_ok}, {31'd0, e.is_data});
                chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
                $display("resp %s rdata=0x%08h", data_data_ok ? "data" : "inst",
                         data_data_ok ? data_rdata : inst_rdata);
            end
        end
    end

    initial begin
        // Reset state, with requests driven to prove outputs are gated.
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #3;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        @(negedge clock); quiet(); @(negedge clock);
        reset = 1'b0;

        // Arbitration priority and in-order routing.
        @(negedge clock); quiet();
        inst_req = 1'b1; inst_addr = 32'h1000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h2000; bus_addr_ok = 1'b1;
        #1;
        chk("prio_bus_addr", bus_addr, 32'h2000);
        chk("prio_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        expect_resp(1'b1, 32'hAAAA);
        $display("req data addr=0x2000");
        @(negedge clock); data_req = 1'b0;
        #1;
        chk("second_bus_addr", bus_addr, 32'h1000);
        chk("second_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
        expect_resp(1'b0, 32'hBBBB);
        $display("req inst addr=0x1000");
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'hAAAA;
        @(negedge clock); bus_data_ok = 1'b1; bus_rdata = 32'hBBBB;
        @(negedge clock); quiet(); #1;
        chk("prio_idle_busy", {31'd0, busy}, 32'd0);

        // Held write stays stable while the requester inputs change.
        pulses = 0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = 32'h3004; data_wdata = 32'hDEADBEEF;
        #1;
        if (data_addr_ok) pulses++;
        chk("hold_c0_addr", bus_addr, 32'h3004);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            data_addr = 32'h5000; data_wstrb = 4'b1111;
            bus_addr_ok = (c == 3);
            #1;
            if (data_addr_ok) pulses++;
            chk("hold_bus_addr", bus_addr, 32'h3004);
            chk("hold_bus_wstrb", {28'd0, bus_wstrb}, 32'h3);
            chk("hold_bus_wr_req", {30'd0, bus_wr, bus_req}, 32'd3);
        end
        chk("hold_wdata", bus_wdata, 32'hDEADBEEF);
        expect_resp(1'b1, 32'h1111_2222);
        $display("req data write addr=0x3004");
        @(negedge clock); quiet(); data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        #1;
        if (data_addr_ok) pulses++;
        bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clock); quiet(); #1;
        chk("hold_addr_ok_pulses", pulses, 32'd1);

        // Outstanding limit.
        inst_req = 1'b1; inst_addr = 32'h100; bus_addr_ok = 1'b1; #1;
        chk("lim_ok0", {31'd0, inst_addr_ok}, 32'd1);
        expect_resp(1'b0, 32'hC0);
        @(negedge clock); inst_addr = 32'h104; #1;
        chk("lim_ok1", {31'd0, inst_addr_ok}, 32'd1);
        expect_resp(1'b0, 32'hC1);
        @(negedge clock); inst_addr = 32'h108; #1;
        chk("lim_full_bus_req", {30'd0, bus_req, inst_addr_ok}, 32'd0);
        chk("lim_full_busy", {31'd0, busy}, 32'd1);
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'hC0;
        @(negedge clock); quiet(); inst_req = 1'b1; inst_addr = 32'h108; bus_addr_ok = 1'b1; #1;
        chk("lim_reopen_bus_req", {30'd0, bus_req, inst_addr_ok}, 32'd3);
        expect_resp(1'b0, 32'hC2);
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'hC1;
        @(negedge clock); bus_data_ok = 1'b1; bus_rdata = 32'hC2;
        @(negedge clock); quiet(); #1;
        chk("lim_idle_busy", {31'd0, busy}, 32'd0);

        // Flush cancels outstanding fetches; data entries survive.
        inst_req = 1'b1; inst_addr = 32'h200; bus_addr_ok = 1'b1;
        @(negedge clock); inst_addr = 32'h204;
        @(negedge clock); quiet(); flush = 1'b1;
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'hE0; #1;
        chk("flush_resp0", {31'd0, inst_data_ok}, 32'd0);
        @(negedge clock); bus_rdata = 32'hE1; #1;
        chk("flush_resp1", {31'd0, inst_data_ok}, 32'd0);
        @(negedge clock); quiet(); #1;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        data_req = 1'b1; data_addr = 32'h400; bus_addr_ok = 1'b1;
        expect_resp(1'b1, 32'hD0);
        @(negedge clock); quiet(); inst_req = 1'b1; inst_addr = 32'h208; bus_addr_ok = 1'b1;
        @(negedge clock); quiet(); flush = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hD0;
        @(negedge clock); quiet(); flush = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hE2; #1;
        chk("flush_same_cycle", {31'd0, inst_data_ok}, 32'd0);
        @(negedge clock); quiet(); #1;
        chk("flush2_busy", {31'd0, busy}, 32'd0);

        // Flush during a held fetch.
        pulses = 0;
        inst_req = 1'b1; inst_addr = 32'h700; #1;
        if (inst_addr_ok) pulses++;
        @(negedge clock); quiet(); flush = 1'b1; #1;
        if (inst_addr_ok) pulses++;
        @(negedge clock); quiet(); bus_addr_ok = 1'b1; #1;
        if (inst_addr_ok) pulses++;
        chk("hflush_bus_addr", bus_addr, 32'h700);
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'hF0; #1;
        if (inst_data_ok) pulses++;
        @(negedge clock); quiet(); #1;
        chk("hflush_no_ok", pulses, 32'd0);
        chk("hflush_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-hold with one entry outstanding.
        data_req = 1'b1; data_addr = 32'h800; bus_addr_ok = 1'b1;
        @(negedge clock); quiet(); inst_req = 1'b1; inst_addr = 32'h900;
        @(negedge clock); quiet(); #1;
        chk("arst_pre_busy", {30'd0, busy, bus_req}, 32'd3);
        #2;
        reset = 1'b1; bus_data_ok = 1'b1; bus_addr_ok = 1'b1; bus_rdata = 32'h99;
        #1;
        chk("arst_bus_req_busy", {30'd0, bus_req, busy}, 32'd0);
        chk("arst_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clock); quiet(); @(negedge clock);
        reset = 1'b0; #1;
        chk("arst_after_busy", {30'd0, bus_req, busy}, 32'd0);
        @(negedge clock); data_req = 1'b1; data_addr = 32'hA00; bus_addr_ok = 1'b1;
        expect_resp(1'b1, 32'h5A5A);
        @(negedge clock); quiet(); bus_data_ok = 1'b1; bus_rdata = 32'h5A5A;
        @(negedge clock); quiet(); #1;
        chk("arst_final_busy", {31'd0, busy}, 32'd0);

        @(negedge clock); #3;
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
